// File: rtl/cv32e40p_trace_pkg.sv
// Shared types for the retirement-trace buffer: the trace entry layout
// and the overflow policy encodings.
package cv32e40p_trace_pkg;

    // Width of the per-entry sequence number carried in trace_entry_t.
    localparam int SEQ_W = 16;

    // Overflow policy encodings.
    localparam int OVF_STALL = 0;
    localparam int OVF_DROP  = 1;

    // One retired instruction as seen by the trace sink.
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic             lost;
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic             rd_we;
        logic [5:0]       rd_addr;
        logic [31:0]      rd_wdata;
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/cv32e40p_trace_compactor.sv
// Combinational retire compactor: maps the valid channels of a cycle onto
// consecutive write slots (lowest channel first) and decides how many of
// them fit, given the free space and the overflow policy.
module cv32e40p_trace_compactor
    import cv32e40p_trace_pkg::*;
#(
    parameter  int NUM_CH   = 2,
    parameter  int LVL_W    = 5,
    parameter  int OVF_MODE = OVF_STALL,
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PC_W     = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]            ret_valid_i,
    input  logic [LVL_W-1:0]             free_i,
    output logic [NUM_CH-1:0][IDX_W-1:0] sel_o,
    output logic [PC_W-1:0]              push_cnt_o,
    output logic [PC_W-1:0]              drop_cnt_o
);

    logic [NUM_CH-1:0][PC_W-1:0] w_prefix;
    logic [PC_W-1:0]             w_total;

    // Running count of valid channels below each channel, and the total.
    always_comb begin
        w_prefix = '0;
        w_total  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_prefix[ch] = w_total;
            w_total      = w_total + PC_W'(ret_valid_i[ch]);
        end
    end

    // Slot s takes the valid channel that has exactly s valid channels below it.
    always_comb begin
        sel_o = '0;
        for (int s = 0; s < NUM_CH; s++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ret_valid_i[ch] && (w_prefix[ch] == PC_W'(s))) begin
                    sel_o[s] = IDX_W'(ch);
                end
            end
        end
    end

    // STALL accepts all or nothing; DROP keeps the oldest channels that fit.
    always_comb begin
        push_cnt_o = '0;
        drop_cnt_o = '0;
        if (OVF_MODE == OVF_DROP) begin
            if (LVL_W'(w_total) <= free_i) begin
                push_cnt_o = w_total;
            end else begin
                push_cnt_o = PC_W'(free_i);
            end
            drop_cnt_o = w_total - push_cnt_o;
        end else begin
            if (free_i >= LVL_W'(NUM_CH)) begin
                push_cnt_o = w_total;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_trace_fifo.sv
// Retirement-trace buffer: captures up to NUM_CH retired instructions per
// cycle into a circular buffer and drains them one entry per cycle.
// Output handshake: an entry transfers on a cycle where out_valid_o and
// out_ready_i are both high; out_valid_o never depends on out_ready_i, and
// ret_ready_o depends only on the registered level.
module cv32e40p_trace_fifo
    import cv32e40p_trace_pkg::*;
#(
    parameter  int NUM_CH   = 2,
    parameter  int DEPTH    = 16,
    parameter  int SEQ_W    = cv32e40p_trace_pkg::SEQ_W,
    parameter  int CNT_W    = 16,
    parameter  int OVF_MODE = OVF_STALL,
    localparam int LVL_W    = $clog2(DEPTH) + 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PC_W     = $clog2(NUM_CH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic [NUM_CH-1:0]        ret_valid_i,
    input  logic [NUM_CH-1:0][31:0]  ret_pc_i,
    input  logic [NUM_CH-1:0][31:0]  ret_instr_i,
    input  logic [NUM_CH-1:0]        ret_rd_we_i,
    input  logic [NUM_CH-1:0][5:0]   ret_rd_addr_i,
    input  logic [NUM_CH-1:0][31:0]  ret_rd_wdata_i,
    output logic                     ret_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output trace_entry_t             out_entry_o,
    output logic [LVL_W-1:0]         level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    trace_entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]        r_level;
    logic [SEQ_W-1:0]        r_seq;
    logic                    r_lost;
    logic                    r_overflow;
    logic [CNT_W-1:0]        r_drop_cnt;

    logic [LVL_W-1:0]               w_free;
    logic [NUM_CH-1:0]              w_valid;
    logic                           w_pop;
    logic [NUM_CH-1:0][IDX_W-1:0]   w_sel;
    logic [PC_W-1:0]                w_push;
    logic [PC_W-1:0]                w_drop;
    logic [CNT_W:0]                 w_cnt_sum;
    trace_entry_t                   w_slot [NUM_CH];

    // Free space comes from the registered level, so a same-cycle pop never adds room.
    assign w_free  = LVL_W'(DEPTH) - r_level;
    // Disabled or flushed cycles see no retires at all.
    assign w_valid = (enable_i && !flush_i) ? ret_valid_i : '0;
    assign w_pop   = (r_level != '0) && out_ready_i && !flush_i;

    cv32e40p_trace_compactor #(
        .NUM_CH   (NUM_CH),
        .LVL_W    (LVL_W),
        .OVF_MODE (OVF_MODE)
    ) u_compactor (
        .ret_valid_i (w_valid),
        .free_i      (w_free),
        .sel_o       (w_sel),
        .push_cnt_o  (w_push),
        .drop_cnt_o  (w_drop)
    );

    // Build the entry for each write slot; only the first stored entry can carry lost.
    always_comb begin
        for (int s = 0; s < NUM_CH; s++) begin
            w_slot[s]          = '0;
            w_slot[s].seq      = r_seq + SEQ_W'(s);
            w_slot[s].lost     = (s == 0) ? r_lost : 1'b0;
            w_slot[s].pc       = ret_pc_i[w_sel[s]];
            w_slot[s].instr    = ret_instr_i[w_sel[s]];
            w_slot[s].rd_we    = ret_rd_we_i[w_sel[s]];
            w_slot[s].rd_addr  = ret_rd_addr_i[w_sel[s]];
            w_slot[s].rd_wdata = ret_rd_wdata_i[w_sel[s]];
        end
    end

    assign w_cnt_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop);

    // Storage write: only slots below the push count are written, so idle channels never land in memory.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NUM_CH; s++) begin
            if (PC_W'(s) < w_push) begin
                r_mem[r_wr_ptr + PTR_W'(s)] <= w_slot[s];
            end
        end
    end

    // Pointers, level, sequence, lost flag and loss counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_seq      <= '0;
            r_lost     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_lost     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_level  <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            r_seq    <= r_seq + SEQ_W'(w_push) + SEQ_W'(w_drop);
            if (w_drop != '0) begin
                r_lost     <= 1'b1;
                r_overflow <= 1'b1;
                r_drop_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
            end else if (w_push != '0) begin
                r_lost <= 1'b0;
            end
        end
    end

    assign ret_ready_o = (OVF_MODE == OVF_DROP) ? 1'b1 : (w_free >= LVL_W'(NUM_CH));
    assign out_valid_o = (r_level != '0);
    assign out_entry_o = r_mem[r_rd_ptr];
    assign level_o     = r_level;
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_cv32e40p_trace_fifo.sv
// Bench for the retirement-trace buffer: a STALL and a DROP instance share
// one stimulus stream; each is checked against a queue-based model.
module tb_cv32e40p_trace_fifo;
    import cv32e40p_trace_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                    enable;
    logic                    flush;
    logic [NUM_CH-1:0]       ret_valid;
    logic [NUM_CH-1:0][31:0] ret_pc;
    logic [NUM_CH-1:0][31:0] ret_instr;
    logic [NUM_CH-1:0]       ret_rd_we;
    logic [NUM_CH-1:0][5:0]  ret_rd_addr;
    logic [NUM_CH-1:0][31:0] ret_rd_wdata;
    logic                    out_ready;

    logic             s_ready, s_valid, s_ovf;
    trace_entry_t     s_entry;
    logic [LVL_W-1:0] s_level;
    logic [CNT_W-1:0] s_dcnt;
    logic             d_ready, d_valid, d_ovf;
    trace_entry_t     d_entry;
    logic [LVL_W-1:0] d_level;
    logic [CNT_W-1:0] d_dcnt;

    cv32e40p_trace_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .OVF_MODE(OVF_STALL)) u_dut_stall (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .ret_rd_we_i(ret_rd_we), .ret_rd_addr_i(ret_rd_addr), .ret_rd_wdata_i(ret_rd_wdata),
        .ret_ready_o(s_ready), .out_valid_o(s_valid), .out_ready_i(out_ready),
        .out_entry_o(s_entry), .level_o(s_level), .overflow_o(s_ovf), .drop_cnt_o(s_dcnt)
    );

    cv32e40p_trace_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .OVF_MODE(OVF_DROP)) u_dut_drop (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .ret_rd_we_i(ret_rd_we), .ret_rd_addr_i(ret_rd_addr), .ret_rd_wdata_i(ret_rd_wdata),
        .ret_ready_o(d_ready), .out_valid_o(d_valid), .out_ready_i(out_ready),
        .out_entry_o(d_entry), .level_o(d_level), .overflow_o(d_ovf), .drop_cnt_o(d_dcnt)
    );

    // Scoreboard: index 0 models the STALL instance, index 1 the DROP instance
    logic [ENTRY_W-1:0] exp_q0[$];
    logic [ENTRY_W-1:0] exp_q1[$];
    logic [SEQ_W-1:0]   m_seq  [2];
    logic               m_lost [2];
    logic               m_ovf  [2];
    logic [CNT_W-1:0]   m_dcnt [2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int q_size(input int inst);
        if (inst == 0) return exp_q0.size();
        return exp_q1.size();
    endfunction

    function automatic logic [ENTRY_W-1:0] q_front(input int inst);
        if (inst == 0) return exp_q0[0];
        return exp_q1[0];
    endfunction

    task automatic q_push(input int inst, input logic [ENTRY_W-1:0] e);
        if (inst == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic q_pop(input int inst);
        if (inst == 0) void'(exp_q0.pop_front());
        else void'(exp_q1.pop_front());
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_seq[i]  = '0;
            m_lost[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_dcnt[i] = '0;
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs currently driven
    task automatic model_step(input int inst);
        int n;
        int lvl;
        int free;
        int keep;
        int dropped;
        int k;
        trace_entry_t e;
        if (flush) begin
            if (inst == 0) exp_q0.delete();
            else exp_q1.delete();
            m_lost[inst] = 1'b0;
            m_ovf[inst]  = 1'b0;
            m_dcnt[inst] = '0;
            return;
        end
        n    = enable ? $countones(ret_valid) : 0;
        lvl  = q_size(inst);
        free = DEPTH - lvl;
        if (inst == 0) begin
            keep    = (free >= NUM_CH) ? n : 0;
            dropped = 0;
        end else begin
            keep    = (n < free) ? n : free;
            dropped = n - keep;
        end
        if (lvl > 0 && out_ready) q_pop(inst);
        k = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (enable && ret_valid[ch]) begin
                if (k < keep) begin
                    e          = '0;
                    e.seq      = m_seq[inst] + SEQ_W'(k);
                    e.lost     = (k == 0) ? m_lost[inst] : 1'b0;
                    e.pc       = ret_pc[ch];
                    e.instr    = ret_instr[ch];
                    e.rd_we    = ret_rd_we[ch];
                    e.rd_addr  = ret_rd_addr[ch];
                    e.rd_wdata = ret_rd_wdata[ch];
                    q_push(inst, e);
                end
                k++;
            end
        end
        m_seq[inst] = m_seq[inst] + SEQ_W'(keep + dropped);
        if (dropped > 0) begin
            m_ovf[inst]  = 1'b1;
            m_lost[inst] = 1'b1;
            if (longint'(m_dcnt[inst]) + dropped >= (longint'(1) << CNT_W)) m_dcnt[inst] = '1;
            else m_dcnt[inst] = m_dcnt[inst] + CNT_W'(dropped);
        end else if (keep > 0) begin
            m_lost[inst] = 1'b0;
        end
    endtask

    task automatic check_inst(input int inst, input string pfx, input logic rdy, input logic vld,
                              input trace_entry_t ent, input logic [LVL_W-1:0] lvl,
                              input logic ovf, input logic [CNT_W-1:0] dcnt);
        int sz;
        logic exp_rdy;
        sz      = q_size(inst);
        exp_rdy = (inst == 0) ? ((DEPTH - sz) >= NUM_CH) : 1'b1;
        check({pfx, ".level"}, lvl, sz);
        check({pfx, ".out_valid"}, vld, sz > 0);
        check({pfx, ".ret_ready"}, rdy, exp_rdy);
        check({pfx, ".overflow"}, ovf, m_ovf[inst]);
        check({pfx, ".drop_cnt"}, dcnt, m_dcnt[inst]);
        if (sz > 0) check({pfx, ".entry"}, ent, q_front(inst));
    endtask

    task automatic check_all();
        check_inst(0, "stall", s_ready, s_valid, s_entry, s_level, s_ovf, s_dcnt);
        check_inst(1, "drop", d_ready, d_valid, d_entry, d_level, d_ovf, d_dcnt);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, ".stall.level"}, s_level, 0);
        check({pfx, ".stall.valid"}, s_valid, 0);
        check({pfx, ".stall.ready"}, s_ready, 1);
        check({pfx, ".stall.ovf"}, s_ovf, 0);
        check({pfx, ".drop.level"}, d_level, 0);
        check({pfx, ".drop.valid"}, d_valid, 0);
        check({pfx, ".drop.ready"}, d_ready, 1);
        check({pfx, ".drop.ovf"}, d_ovf, 0);
        check({pfx, ".drop.dcnt"}, d_dcnt, 0);
    endtask

    // Driver tasks
    task automatic rand_data();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ret_pc[ch]       = $urandom;
            ret_instr[ch]    = $urandom;
            ret_rd_we[ch]    = 1'($urandom_range(0, 1));
            ret_rd_addr[ch]  = 6'($urandom_range(0, 63));
            ret_rd_wdata[ch] = $urandom;
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, clock, then check
    task automatic cycle(input logic [NUM_CH-1:0] v, input logic rdy, input logic fl, input logic en);
        ret_valid = v;
        out_ready = rdy;
        flush     = fl;
        enable    = en;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        enable    = 1'b0;
        flush     = 1'b0;
        ret_valid = '0;
        out_ready = 1'b0;
        rand_data();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        check_all();

        // Single retire on ch0, then pop
        ret_pc[0] = 32'h80; ret_instr[0] = 32'h00100093;
        ret_rd_we[0] = 1'b1; ret_rd_addr[0] = 6'd1; ret_rd_wdata[0] = 32'd1;
        cycle(2'b01, 1'b0, 1'b0, 1'b1);
        check("t1.valid", d_valid, 1);
        check("t1.seq", d_entry.seq, 0);
        check("t1.pc", d_entry.pc, 32'h80);
        check("t1.level", d_level, 1);
        cycle(2'b00, 1'b1, 1'b0, 1'b1);
        check("t1.level_pop", d_level, 0);

        // Two channels in one cycle drain in channel order
        rand_data();
        ret_pc[0] = 32'h100; ret_pc[1] = 32'h104;
        cycle(2'b11, 1'b0, 1'b0, 1'b1);
        check("t2.first_pc", d_entry.pc, 32'h100);
        check("t2.first_seq", d_entry.seq, 1);
        cycle(2'b00, 1'b1, 1'b0, 1'b1);
        check("t2.second_pc", d_entry.pc, 32'h104);
        check("t2.second_seq", d_entry.seq, 2);
        cycle(2'b00, 1'b1, 1'b0, 1'b1);

        // Fill to 15 with the sink stalled
        rand_data();
        cycle(2'b01, 1'b0, 1'b0, 1'b1);
        repeat (7) begin
            rand_data();
            cycle(2'b11, 1'b0, 1'b0, 1'b1);
        end
        check("t3.stall_ready", s_ready, 0);
        check("t3.stall_level", s_level, 15);
        rand_data();
        cycle(2'b11, 1'b0, 1'b0, 1'b1);
        check("t3.stall_hold", s_level, 15);
        check("t4.drop_level", d_level, 16);
        check("t4.drop_cnt", d_dcnt, 1);
        check("t4.overflow", d_ovf, 1);
        rand_data();
        cycle(2'b11, 1'b1, 1'b0, 1'b1);
        check("t3.stall_level_pop", s_level, 14);
        check("t3.stall_ready_back", s_ready, 1);
        check("t5.drop_full_pop_level", d_level, 15);
        check("t5.drop_cnt", d_dcnt, 3);
        rand_data();
        cycle(2'b01, 1'b0, 1'b0, 1'b1);
        repeat (20) cycle(2'b00, 1'b1, 1'b0, 1'b1);

        // Flush with simultaneous push and pop at level 5
        repeat (5) begin
            rand_data();
            cycle(2'b01, 1'b0, 1'b0, 1'b1);
        end
        check("t6.pre_level", d_level, 5);
        rand_data();
        cycle(2'b11, 1'b1, 1'b1, 1'b1);
        check("t6.level", d_level, 0);
        check("t6.valid", d_valid, 0);
        check("t6.overflow", d_ovf, 0);
        check("t6.drop_cnt", d_dcnt, 0);
        check("t6.stall_level", s_level, 0);
        rand_data();
        cycle(2'b01, 1'b0, 1'b0, 1'b1);

        // Randomised traffic with varying sink pressure, a mid-run reset
        for (int i = 0; i < 4000; i++) begin
            int pct;
            if (i == 2000) begin
                rst = 1'b1;
                #1;
                check_reset_vals("midreset");
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                check_all();
            end
            pct = ((i / 250) % 2 == 1) ? 85 : 30;
            rand_data();
            cycle(NUM_CH'($urandom), $urandom_range(0, 99) < pct,
                  $urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0);
        end

        repeat (20) cycle(2'b00, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
